// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-client round-robin front end for a 16x8 dual-port RAM.
// Optional RAM_ARB_INIT_CLEAR_EN zeroes every word after each reset.
module ram_port_arbiter #(
  parameter int NCLI = 2,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NCLI-1:0]    wr_req,
  input  logic [NCLI*AW-1:0] wr_addr,
  input  logic [NCLI*DW-1:0] wr_data,
  output logic [NCLI-1:0]    wr_gnt,
  input  logic [NCLI-1:0]    rd_req,
  input  logic [NCLI*AW-1:0] rd_addr,
  output logic [NCLI-1:0]    rd_gnt,
  output logic [NCLI-1:0]    rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic               busy,
  output logic               ram_we,
  output logic [AW-1:0]      ram_w_add,
  output logic [DW-1:0]      ram_data_in,
  output logic               ram_re,
  output logic [AW-1:0]      ram_r_add,
  input  logic [DW-1:0]      ram_data_out
);

  logic run;

  logic wr_pri_q, wr_pri_d;
  logic rd_pri_q, rd_pri_d;

  logic [NCLI-1:0] rd_valid_q, rd_valid_d;

`ifdef RAM_ARB_INIT_CLEAR_EN
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  // State and clear-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk the clear counter once, then hand over to arbitration
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (clr_cnt_q == {AW{1'b1}}) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign run  = (state_q == S_RUN);
  assign busy = ~run;
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Write-port pick: lone requester wins, ties go to the pointer
  always_comb begin
    wr_gnt = '0;
    if (run) begin
      unique case (1'b1)
        wr_req[0] & ~(wr_req[1] & wr_pri_q):
          wr_gnt = 2'b01;
        wr_req[1] & ~(wr_req[0] & ~wr_pri_q):
          wr_gnt = 2'b10;
        default:
          wr_gnt = '0;
      endcase
    end
  end

  // Read-port pick, same rule with its own pointer
  always_comb begin
    rd_gnt = '0;
    if (run) begin
      unique case (1'b1)
        rd_req[0] & ~(rd_req[1] & rd_pri_q):
          rd_gnt = 2'b01;
        rd_req[1] & ~(rd_req[0] & ~rd_pri_q):
          rd_gnt = 2'b10;
        default:
          rd_gnt = '0;
      endcase
    end
  end

  // Pointer moves to the other client after a grant
  always_comb begin
    wr_pri_d = wr_pri_q;
    rd_pri_d = rd_pri_q;
    if (|wr_gnt) begin
      wr_pri_d = wr_gnt[0];
    end
    if (|rd_gnt) begin
      rd_pri_d = rd_gnt[0];
    end
  end

  // Owner tag for the read issued this cycle
  always_comb begin
    rd_valid_d = rd_gnt;
  end

  // Pointer and read-owner registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pri_q   <= 1'b0;
      rd_pri_q   <= 1'b0;
      rd_valid_q <= '0;
    end else begin
      wr_pri_q   <= wr_pri_d;
      rd_pri_q   <= rd_pri_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Write-port mux; the clear sequence overrides client traffic
  always_comb begin
    ram_we      = 1'b0;
    ram_w_add   = '0;
    ram_data_in = '0;
    unique case (1'b1)
      wr_gnt[0]: begin
        ram_we      = 1'b1;
        ram_w_add   = wr_addr[AW-1:0];
        ram_data_in = wr_data[DW-1:0];
      end
      wr_gnt[1]: begin
        ram_we      = 1'b1;
        ram_w_add   = wr_addr[2*AW-1:AW];
        ram_data_in = wr_data[2*DW-1:DW];
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
`ifdef RAM_ARB_INIT_CLEAR_EN
    if (!run) begin
      ram_we      = 1'b1;
      ram_w_add   = clr_cnt_q;
      ram_data_in = '0;
    end
`endif
  end

  // Read-port mux
  always_comb begin
    ram_re    = 1'b0;
    ram_r_add = '0;
    unique case (1'b1)
      rd_gnt[0]: begin
        ram_re    = 1'b1;
        ram_r_add = rd_addr[AW-1:0];
      end
      rd_gnt[1]: begin
        ram_re    = 1'b1;
        ram_r_add = rd_addr[2*AW-1:AW];
      end
      default: begin
        ram_re = 1'b0;
      end
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = ram_data_out;

endmodule
